// File: rtl/maindec_pkg.sv
// +----------------------------------------------------------------------+
// | maindec_pkg: shared types, opcodes and control helpers for maindec   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package maindec_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {NONE, RTYPE, LDUR, STUR, CBZ, ILLEGAL} class_t;

  localparam int          OP_BASE_W = 11;
  localparam logic [10:0] OP_LDUR   = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR   = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD    = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB    = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND    = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR    = 11'b101_0101_0000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b1011_0100;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic [1:0] aluop;
  } ctrl_t;

  // Datapath mux settings per instruction class; unused classes drive 0.
  function automatic ctrl_t static_ctrl(input class_t c);
    ctrl_t r;
    r = '0;
    case (c)
      RTYPE:   r.aluop = ALUOP_R;
      LDUR:    begin r.alusrc = 1'b1; r.memtoreg = 1'b1; r.aluop = ALUOP_MEM; end
      STUR:    begin r.reg2loc = 1'b1; r.alusrc = 1'b1; r.aluop = ALUOP_MEM; end
      CBZ:     begin r.reg2loc = 1'b1; r.aluop = ALUOP_BR; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maindec_mc_if.sv
// +----------------------------------------------------------------------+
// | maindec_mc_if: instruction/memory inputs and datapath control bus    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface maindec_mc_if #(
  parameter int OP_W  = 11,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  Op;
  logic             mem_ready;
  logic             Reg2Loc;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic [1:0]       ALUOp;
  logic             IRWrite;
  logic             PCWrite;
  logic             illegal;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired;

  // master: the decoder; slave: instruction register and datapath side
  modport master (
    input  Op, mem_ready,
    output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, IRWrite, PCWrite, illegal, mem_timeout, retired
  );
  modport slave (
    output Op, mem_ready,
    input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, IRWrite, PCWrite, illegal, mem_timeout, retired
  );
endinterface

`default_nettype wire

// File: rtl/maindec_class.sv
// +----------------------------------------------------------------------+
// | maindec_class: combinational LEGv8 opcode -> instruction class       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module maindec_class
  import maindec_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] Op,
  output class_t          cls
);

  logic w_hi_zero;

  // Opcode bits above the base field must be zero for a legal instruction.
  generate
    if (OP_W > OP_BASE_W) begin : g_wide
      assign w_hi_zero = ~|Op[OP_W-1:OP_BASE_W];
    end else begin : g_exact
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    cls = ILLEGAL;
    if (w_hi_zero) begin
      if (Op[10:0] == OP_LDUR)                 cls = LDUR;
      else if (Op[10:0] == OP_STUR)            cls = STUR;
      else if (Op[10:3] == OP_CBZ_HI)          cls = CBZ;
      else if (Op[10:0] == OP_ADD || Op[10:0] == OP_SUB ||
               Op[10:0] == OP_AND || Op[10:0] == OP_ORR)
                                               cls = RTYPE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/maindec_mc.sv
// +----------------------------------------------------------------------+
// | maindec_mc: multi-cycle LEGv8 main decoder FSM (MAINDEC_MC_TRAP_EN   |
// | makes illegal opcodes trap until reset). Revision: 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

module maindec_mc
  import maindec_pkg::*;
#(
  parameter int OP_W         = 11,
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  maindec_mc_if.master bus
);

  localparam int WC_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_t           state_q, state_d;
  class_t           cls_q, cls_d;
  class_t           w_cls;
  ctrl_t            w_ctrl;
  logic             run_q, run_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             w_wait_limit;

  maindec_class #(.OP_W(OP_W)) u_class (
    .Op  (bus.Op),
    .cls (w_cls)
  );

  generate
    if (MEM_WAIT_MAX > 0) begin : g_timeout
      assign w_wait_limit = (wcnt_q == WC_W'(MEM_WAIT_MAX - 1));
    end else begin : g_no_timeout
      assign w_wait_limit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      cls_q     <= NONE;
      run_q     <= 1'b0;
      wcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      run_q     <= run_d;
      wcnt_q    <= wcnt_d;
      retired_q <= retired_d;
    end
  end

  // run_q keeps every output low until the first clock after reset release,
  // so the FETCH strobes never appear while reset is held.
  always_comb begin
    state_d         = state_q;
    cls_d           = cls_q;
    run_d           = 1'b1;
    wcnt_d          = wcnt_q;
    retired_d       = retired_q;
    w_ctrl          = '0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.Branch      = 1'b0;
    bus.illegal     = 1'b0;
    bus.mem_timeout = 1'b0;
    if (run_q) begin
      if (state_q == EXEC || state_q == MEM || state_q == WB)
        w_ctrl = static_ctrl(cls_q);
      unique case (state_q)
        FETCH: begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = DECODE;
        end
        DECODE: begin
          cls_d = w_cls;
          if (w_cls == ILLEGAL) begin
            bus.illegal = 1'b1;
`ifdef MAINDEC_MC_TRAP_EN
            state_d     = TRAP;
`else
            retired_d   = retired_q + CNT_W'(1);
            state_d     = FETCH;
`endif
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          wcnt_d = '0;
          case (cls_q)
            CBZ: begin
              bus.Branch = 1'b1;
              retired_d  = retired_q + CNT_W'(1);
              state_d    = FETCH;
            end
            LDUR, STUR: state_d = MEM;
            RTYPE:      state_d = WB;
            default:    state_d = FETCH;
          endcase
        end
        MEM: begin
          bus.MemRead  = (cls_q == LDUR);
          bus.MemWrite = (cls_q == STUR);
          // A ready on the limit cycle wins over the timeout.
          if (bus.mem_ready) begin
            if (cls_q == LDUR) begin
              state_d = WB;
            end else begin
              retired_d = retired_q + CNT_W'(1);
              state_d   = FETCH;
            end
          end else if (w_wait_limit) begin
            bus.mem_timeout = 1'b1;
            state_d         = FETCH;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        WB: begin
          bus.RegWrite = 1'b1;
          retired_d    = retired_q + CNT_W'(1);
          state_d      = FETCH;
        end
        TRAP: begin
          bus.illegal = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.Reg2Loc  = w_ctrl.reg2loc;
  assign bus.ALUSrc   = w_ctrl.alusrc;
  assign bus.MemtoReg = w_ctrl.memtoreg;
  assign bus.ALUOp    = w_ctrl.aluop;
  assign bus.retired  = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_maindec_mc.sv
// +----------------------------------------------------------------------+
// | tb_maindec_mc: directed bench with a per-instruction trace model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_maindec_mc;

  localparam int MAXW = 4;
  localparam int K_R = 1, K_LD = 2, K_ST = 3, K_CB = 4, K_IL = 5;

  typedef struct packed {
    logic       irw, pcw, r2l, asrc, m2r, rw, mr, mw, br;
    logic [1:0] aluop;
    logic       ill, tmo;
    logic [3:0] ret;
  } exp_t;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [3:0]  m_ret = '0;
  item_t       exp_q[$];
  item_t       it_c;
  logic [16:0] got_v;
  int          n;

  maindec_mc_if #(.OP_W(11), .CNT_W(4)) bus ();

  maindec_mc #(.OP_W(11), .MEM_WAIT_MAX(MAXW), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign got_v = {bus.IRWrite, bus.PCWrite, bus.Reg2Loc, bus.ALUSrc, bus.MemtoReg,
                  bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.ALUOp,
                  bus.illegal, bus.mem_timeout, bus.retired};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      it_c = exp_q.pop_front();
      total++;
      if (got_v !== it_c.v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", it_c.tag, cyc, got_v, it_c.v);
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int model_class(input logic [10:0] op);
    casez (op)
      11'b111_1100_0010: return K_LD;
      11'b111_1100_0000: return K_ST;
      11'b101_1010_0???: return K_CB;
      11'b100_0101_1000, 11'b110_0101_1000,
      11'b100_0101_0000, 11'b101_0101_0000: return K_R;
      default: return K_IL;
    endcase
  endfunction

  function automatic exp_t static_exp(input int k);
    exp_t e;
    e = '0;
    case (k)
      K_R:  e.aluop = 2'b10;
      K_LD: begin e.asrc = 1'b1; e.m2r = 1'b1; end
      K_ST: begin e.r2l = 1'b1; e.asrc = 1'b1; end
      K_CB: begin e.r2l = 1'b1; e.aluop = 2'b01; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input logic [10:0] op, input logic rdy, input exp_t e, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    bus.Op        = op;
    bus.mem_ready = rdy;
    it.v   = e;
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  task automatic do_reset();
    item_t it;
    exp_t  z;
    z = '0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    it.v   = z;
    it.tag = "reset";
    exp_q.push_back(it);
    #1;
    check_lit("reset_immediate", int'(got_v), 0);
    m_ret = '0;
    repeat (2) step(11'h7C2, 1'b1, z, "reset");
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Emits the expected cycle-by-cycle trace of one instruction while driving it.
  // rdy_at: MEM cycle (1-based) that sees mem_ready, 0 = never.
  task automatic run_instr(input logic [10:0] op, input int rdy_at, input logic nrdy,
                           input int abort_at, input int ret_lit, input string tag,
                           output int ncyc);
    exp_t       e, s;
    int         k;
    logic       rdy;
    logic [10:0] nz;
    nz   = op ^ 11'h5A5;
    ncyc = 0;
    e = '0; e.irw = 1'b1; e.pcw = 1'b1; e.ret = m_ret;
    step(nz, nrdy, e, tag); ncyc++;
    if (ret_lit >= 0) begin
      #1;
      check_lit({tag, "_retired"}, int'(bus.retired), ret_lit);
    end
    k = model_class(op);
    e = '0; e.ill = (k == K_IL); e.ret = m_ret;
    step(op, nrdy, e, tag); ncyc++;
    if (k == K_IL) begin
`ifdef MAINDEC_MC_TRAP_EN
      for (int i = 0; i < 10; i++) begin
        e = '0; e.ill = 1'b1; e.ret = m_ret;
        step(nz, 1'b1, e, tag); ncyc++;
      end
`else
      m_ret++;
`endif
      return;
    end
    s = static_exp(k);
    e = s; e.ret = m_ret; e.br = (k == K_CB);
    step(nz, nrdy, e, tag); ncyc++;
    if (k == K_CB) begin m_ret++; return; end
    if (k == K_R) begin
      e = s; e.rw = 1'b1; e.ret = m_ret;
      step(nz, nrdy, e, tag); ncyc++;
      m_ret++;
      return;
    end
    for (int m = 1; m <= MAXW; m++) begin
      if (m == abort_at) begin
        do_reset();
        return;
      end
      rdy = (m == rdy_at);
      e = s; e.ret = m_ret; e.mr = (k == K_LD); e.mw = (k == K_ST);
      e.tmo = !rdy && (m == MAXW);
      step(nz, rdy, e, tag); ncyc++;
      if (e.tmo) return;
      if (rdy) break;
    end
    if (k == K_LD) begin
      e = s; e.rw = 1'b1; e.ret = m_ret;
      step(nz, 1'b0, e, tag); ncyc++;
    end
    m_ret++;
  endtask

  initial begin
    logic [10:0] rops [4];
    rops[0] = 11'b100_0101_1000;
    rops[1] = 11'b110_0101_1000;
    rops[2] = 11'b100_0101_0000;
    rops[3] = 11'b101_0101_0000;
    bus.Op        = '0;
    bus.mem_ready = 1'b0;
    do_reset();

    run_instr(rops[0], 0, 1'b0, 0, 0, "add", n);          check_lit("add_lat", n, 4);
    run_instr(rops[1], 0, 1'b1, 0, 1, "sub", n);
    run_instr(rops[2], 0, 1'b1, 0, -1, "and", n);
    run_instr(rops[3], 0, 1'b1, 0, -1, "orr", n);
    run_instr(11'b101_1010_0101, 0, 1'b1, 0, 4, "cbz", n); check_lit("cbz_lat", n, 3);
    run_instr(11'b111_1100_0010, 3, 1'b0, 0, 5, "ldur3", n); check_lit("ldur3_lat", n, 7);
    run_instr(11'b111_1100_0010, 1, 1'b1, 0, -1, "ldur1", n); check_lit("ldur1_lat", n, 5);
    run_instr(11'b111_1100_0000, 2, 1'b0, 0, 7, "stur2", n); check_lit("stur2_lat", n, 5);
    run_instr(11'b111_1100_0000, 0, 1'b0, 0, 8, "stur_to", n); check_lit("stur_to_lat", n, 7);
    run_instr(11'b111_1100_0000, 4, 1'b0, 0, 8, "stur4", n); check_lit("stur4_lat", n, 7);
`ifdef MAINDEC_MC_TRAP_EN
    run_instr(11'h7FF, 0, 1'b0, 0, 9, "trap", n);         check_lit("trap_lat", n, 12);
    do_reset();
`else
    run_instr(11'h7FF, 0, 1'b0, 0, 9, "nop", n);          check_lit("nop_lat", n, 2);
    run_instr(rops[0], 0, 1'b0, 0, 10, "add_after_nop", n);
`endif
    run_instr(11'b111_1100_0010, 0, 1'b0, 2, -1, "ldur_abort", n);
    run_instr(rops[0], 0, 1'b0, 0, 0, "add_after_abort", n);

    do_reset();
    for (int i = 0; i < 16; i++)
      run_instr(rops[i % 4], 0, 1'b0, 0, (i == 15) ? 15 : -1, "wrap", n);
    run_instr(rops[0], 0, 1'b0, 0, 0, "wrap_end", n);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Multi-cycle successor to the single-cycle LEGv8 main decoder.
- An FSM that sequences FETCH/DECODE/EXEC/MEM/WB and drives the same datapath control set (Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp).
- Adds PC/IR write strobes, a data-memory wait handshake with timeout, and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath.

Parameters:
- OP_W, 11, opcode field width; decode uses Op[10:0], extra MSBs must be 0 or the opcode is illegal.
- MEM_WAIT_MAX, 16, max cycles spent in MEM waiting for mem_ready; 0 = wait forever.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  OP_W  opcode from instruction register; sampled in DECODE only.
- mem_ready  in  1  data memory completes access this cycle.
- Reg2Loc, ALUSrc, MemtoReg  out  1 each  datapath muxes.
- RegWrite, MemRead, MemWrite, Branch  out  1 each  strobes.
- ALUOp  out  2  ALU control class.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  PC <= PC+4.
- illegal  out  1  illegal opcode indication.
- mem_timeout  out  1  one-cycle pulse on MEM abandon.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Reset (reset=0, async): state=FETCH, class=NONE, retired=0, all outputs 0.
- Classes decoded in DECODE and registered:
  - LDUR: 111_1100_0010
  - STUR: 111_1100_0000
  - CBZ: 101_1010_0xxx
  - ADD: 100_0101_1000
  - SUB: 110_0101_1000
  - AND: 100_0101_0000
  - ORR: 101_0101_0000
  - Anything else: ILLEGAL.
- Static controls come from the registered class and are held from the cycle after DECODE until the return to FETCH; don't-cares are driven 0.
  - R-type: Reg2Loc=0, ALUSrc=0, MemtoReg=0, ALUOp=10.
  - LDUR: Reg2Loc=0, ALUSrc=1, MemtoReg=1, ALUOp=00.
  - STUR: Reg2Loc=1, ALUSrc=1, MemtoReg=0, ALUOp=00.
  - CBZ: Reg2Loc=1, ALUSrc=0, MemtoReg=0, ALUOp=01.
- States:
  - FETCH: IRWrite=1, PCWrite=1 for exactly one cycle -> DECODE.
  - DECODE: latch class. Legal -> EXEC. ILLEGAL -> see Optional Feature.
  - EXEC: CBZ asserts Branch=1 for one cycle, retired++, -> FETCH. R-type -> WB. LDUR/STUR -> MEM; wait counter cleared on entry.
  - MEM: LDUR holds MemRead=1, STUR holds MemWrite=1, while waiting.
    - mem_ready=1 -> strobe drops next cycle; LDUR -> WB; STUR -> FETCH with retired++.
    - Timeout: if MEM_WAIT_MAX>0 and the wait count reaches MEM_WAIT_MAX with mem_ready still 0, pulse mem_timeout for one cycle, leave retired unchanged, -> FETCH, no RegWrite.
    - mem_ready=1 on the same cycle the count reaches the limit counts as success; no timeout.
  - WB: RegWrite=1 for one cycle, retired++ -> FETCH.
- Latency:
  - CBZ: 3 cycles.
  - R-type: 4 cycles.
  - STUR: 3+waits cycles (min 4).
  - LDUR: 4+waits cycles (min 5).
- retired wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored outside MEM.
- Async reset mid-instruction aborts immediately with no partial strobes; a FETCH follows the first clock after deassertion.

Optional Feature:
- Macro: MAINDEC_MC_TRAP_EN.
- Defined: ILLEGAL in DECODE -> TRAP state. illegal=1 is sticky and all strobes are 0 until reset. Only reset exits TRAP.
- Undefined: ILLEGAL is treated as a NOP. illegal pulses for one cycle in the DECODE->FETCH transition, retired++, no strobes, -> FETCH.

Decomposition:
- Shared package maindec_pkg:
  - state_t enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - class_t enum: NONE, RTYPE, LDUR, STUR, CBZ, ILLEGAL.
  - opcode localparams and ALUOp constants ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10.
- Sub-module maindec_class: purely combinational Op -> class_t classifier, reusable by the single-cycle decoder.
- FSM, counters and output logic live in maindec_mc.

Test Plan:
- ADD 100_0101_1000 with mem_ready=0 -> IRWrite/PCWrite in cycle 1, RegWrite=1 only in cycle 4, ALUOp=10 throughout EXEC/WB, retired 0->1.
- LDUR 111_1100_0010, mem_ready high on the 3rd MEM cycle -> MemRead=1 for 3 cycles, then WB with MemtoReg=1 and RegWrite=1; total 7 cycles.
- STUR with mem_ready never asserted, MEM_WAIT_MAX=4 -> MemWrite=1 for 4 cycles, mem_timeout pulse, retired unchanged, next cycle FETCH.
- CBZ 101_1010_0101 -> Branch=1 for one cycle in EXEC, ALUOp=01, Reg2Loc=1, 3-cycle instruction.
- Op=111_1111_1111 -> with MAINDEC_MC_TRAP_EN: illegal stays 1 and no IRWrite for 10 cycles; without: one-cycle illegal pulse, then IRWrite next cycle.
- Assert reset low mid-MEM of an LDUR -> all outputs 0 immediately; after release, FETCH with retired=0. Separately, preset retired to all-ones via 2^CNT_W R-types (CNT_W=4) -> wraps to 0.
